// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC time-pulse generator: sequencer states,
// pulse count and reset constants for the one-hot Txx vector.
package agc_timing_pkg;
  localparam int unsigned NUM_TP = 12;

  typedef enum logic [1:0] {
    RESTART,
    JAM,
    RUN,
    STOPPED
  } tp_state_t;

  localparam logic [NUM_TP-1:0] TP_RESET = '0;
  localparam logic [NUM_TP-1:0] TP_T01   = NUM_TP'(1);
endpackage

// File: rtl/agc_timepulse_gen_if.sv
// Control-section bundle: restart/monitor requests in, time pulses and status out.
interface agc_timepulse_gen_if;
  logic STRT2, MSTP, MSTRT;
  logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
  logic T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_;
  logic T12USE_, GOJAM, MSTPIT;

  modport master (
    input  STRT2, MSTP, MSTRT,
    output T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12,
    output T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
    output T12USE_, GOJAM, MSTPIT
  );

  modport slave (
    output STRT2, MSTP, MSTRT,
    input  T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12,
    input  T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
    input  T12USE_, GOJAM, MSTPIT
  );
endinterface

// File: rtl/agc_tp_ring.sv
// One-hot T01..T12 ring with per-pulse phase counter; clear beats load beats advance.
module agc_tp_ring
  import agc_timing_pkg::*;
#(
  parameter int unsigned CYCLES_PER_T = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  output logic [NUM_TP-1:0] tp,
  output logic              last_phase
);
  localparam int unsigned PW = (CYCLES_PER_T > 1) ? $clog2(CYCLES_PER_T) : 1;
  localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_T - 1);

  logic [PW-1:0] phase;

  assign last_phase = (phase == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp    <= TP_RESET;
      phase <= '0;
    end else if (clear) begin
      tp    <= TP_RESET;
      phase <= '0;
    end else if (load) begin
      tp    <= TP_T01;
      phase <= '0;
    end else if (advance) begin
      if (last_phase) begin
        phase <= '0;
        tp    <= {tp[NUM_TP-2:0], tp[NUM_TP-1]};
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end
endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC time-pulse generator: restart (GOJAM) sequencing, MCT ring control,
// monitor stop and single-step.
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int unsigned CYCLES_PER_T = 2
) (
  input logic                 CLOCK,
  input logic                 rst_,
  agc_timepulse_gen_if.master bus
);
  tp_state_t         state, state_nxt;
  logic [NUM_TP-1:0] tp;
  logic              last_phase, clear, load, advance;
  logic              gojam, gojam_nxt, mstpit, mstpit_nxt;
  logic              t12use_l, t12use_l_nxt;
  logic              mstrt_s, mstrt_q, mstrt_rise;
  logic              step_t11, step_t12;

  agc_tp_ring #(.CYCLES_PER_T(CYCLES_PER_T)) u_ring (
    .clk       (CLOCK),
    .rst_n     (rst_),
    .clear     (clear),
    .load      (load),
    .advance   (advance),
    .tp        (tp),
    .last_phase(last_phase)
  );

  assign mstrt_rise = mstrt_s & ~mstrt_q;
  assign step_t11   = last_phase & tp[NUM_TP-2];
  assign step_t12   = last_phase & tp[NUM_TP-1];

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      state    <= RESTART;
      gojam    <= 1'b1;
      mstpit   <= 1'b0;
      t12use_l <= 1'b1;
      mstrt_s  <= 1'b0;
      mstrt_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gojam    <= gojam_nxt;
      mstpit   <= mstpit_nxt;
      t12use_l <= t12use_l_nxt;
      mstrt_s  <= bus.MSTRT;
      mstrt_q  <= mstrt_s;
    end
  end

  // During T12, a high T12USE_ is itself the latched stop decision.
  always_comb begin
    state_nxt    = state;
    gojam_nxt    = gojam;
    mstpit_nxt   = mstpit;
    t12use_l_nxt = t12use_l;
    clear        = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;
    if (bus.STRT2) begin
      state_nxt    = RESTART;
      clear        = 1'b1;
      gojam_nxt    = 1'b1;
      mstpit_nxt   = 1'b0;
      t12use_l_nxt = 1'b1;
    end else begin
      unique case (state)
        RESTART: begin
          load      = 1'b1;
          state_nxt = JAM;
        end
        JAM: begin
          advance = 1'b1;
          if (step_t11) t12use_l_nxt = 1'b0;
          if (step_t12) begin
            state_nxt    = RUN;
            gojam_nxt    = 1'b0;
            t12use_l_nxt = 1'b1;
          end
        end
        RUN: begin
          advance = 1'b1;
          if (step_t11) t12use_l_nxt = bus.MSTP;
          if (step_t12) begin
            t12use_l_nxt = 1'b1;
            if (t12use_l) begin
              advance    = 1'b0;
              clear      = 1'b1;
              state_nxt  = STOPPED;
              mstpit_nxt = 1'b1;
            end
          end
        end
        STOPPED: begin
          if (mstrt_rise || !bus.MSTP) begin
            load       = 1'b1;
            state_nxt  = RUN;
            mstpit_nxt = 1'b0;
          end
        end
        default: state_nxt = RESTART;
      endcase
    end
  end

  assign {bus.T12, bus.T11, bus.T10, bus.T09, bus.T08, bus.T07,
          bus.T06, bus.T05, bus.T04, bus.T03, bus.T02, bus.T01} = tp;
  assign {bus.T12_, bus.T11_, bus.T10_, bus.T09_, bus.T08_, bus.T07_,
          bus.T06_, bus.T05_, bus.T04_, bus.T03_, bus.T02_, bus.T01_} = ~tp;
  assign bus.T12USE_ = t12use_l;
  assign bus.GOJAM   = gojam;
  assign bus.MSTPIT  = mstpit;
endmodule
